// File: rtl/hex_data_entry.sv
// Nibble-at-a-time operand editor for the systolic cell demo: edits a shadow
// copy of {prop, par, inp} and publishes it to the cell only on commit.
module hex_data_entry #(
    parameter int DATA_WIDTH   = 8,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              key_inc,
    input  logic                              key_dec,
    input  logic                              key_next,
    input  logic                              key_commit,
    input  logic                              preset_load,
    input  logic [DATA_WIDTH-1:0]             preset_inp,
    input  logic [DATA_WIDTH-1:0]             preset_par,
    input  logic [2*DATA_WIDTH-1:0]           preset_prop,
    output logic [DATA_WIDTH-1:0]             inp,
    output logic [DATA_WIDTH-1:0]             par,
    output logic [2*DATA_WIDTH-1:0]           prop,
    output logic                              commit_valid,
    output logic [$clog2(DATA_WIDTH)-1:0]     cursor,
    output logic [15:0]                       display_number,
    output logic [3:0]                        digit_blank
);

    localparam int NIBBLES  = DATA_WIDTH;
    localparam int SHADOW_W = 4 * DATA_WIDTH;
    localparam int CW       = $clog2(DATA_WIDTH);
    localparam int NWIN     = (SHADOW_W + 15) / 16;
    localparam int PAD_W    = 16 * NWIN;
    localparam int BW       = $clog2(BLINK_CYCLES);

    logic [SHADOW_W-1:0]     shadow_reg, shadow_next, shadow_edit;
    logic [DATA_WIDTH-1:0]   inp_reg, par_reg;
    logic [2*DATA_WIDTH-1:0] prop_reg;
    logic                    commit_valid_reg;
    logic [CW-1:0]           cursor_reg, cursor_next;
    logic [BW-1:0]           blink_cnt_reg, blink_cnt_next;
    logic                    blink_phase_reg, blink_phase_next;

    logic [3:0]              nibbles [NIBBLES];
    logic [3:0]              cur_nibble, nibble_new;
    logic                    key_any, do_commit, do_edit;

    assign key_any   = key_inc | key_dec | key_next | key_commit | preset_load;
    assign do_commit = key_commit & ~preset_load;
    assign do_edit   = ~preset_load & ~key_commit;

    // Only the nibble under the cursor takes the edited value
    genvar gi;
    generate
        for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign nibbles[gi] = shadow_reg[4*gi +: 4];
            assign shadow_edit[4*gi +: 4] = (cursor_reg == CW'(gi)) ? nibble_new
                                                                   : shadow_reg[4*gi +: 4];
        end
    endgenerate

    assign cur_nibble = nibbles[cursor_reg];

    always_comb begin
        nibble_new = cur_nibble;
        if (key_inc && !key_dec) begin
            nibble_new = cur_nibble + 4'd1;
        end else if (key_dec && !key_inc) begin
            nibble_new = cur_nibble - 4'd1;
        end
    end

    always_comb begin
        shadow_next = shadow_reg;
        cursor_next = cursor_reg;
        if (preset_load) begin
            shadow_next = {preset_prop, preset_par, preset_inp};
        end else if (do_edit) begin
            shadow_next = shadow_edit;
            if (key_next) begin
                cursor_next = (cursor_reg == CW'(NIBBLES - 1)) ? '0 : cursor_reg + CW'(1);
            end
        end
    end

    // Any key restarts the blink so the cursor digit is shown immediately
    always_comb begin
        blink_cnt_next   = blink_cnt_reg + BW'(1);
        blink_phase_next = blink_phase_reg;
        if (key_any) begin
            blink_cnt_next   = '0;
            blink_phase_next = 1'b0;
        end else if (blink_cnt_reg == BW'(BLINK_CYCLES - 1)) begin
            blink_cnt_next   = '0;
            blink_phase_next = ~blink_phase_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shadow_reg       <= '0;
            inp_reg          <= '0;
            par_reg          <= '0;
            prop_reg         <= '0;
            commit_valid_reg <= 1'b0;
            cursor_reg       <= '0;
            blink_cnt_reg    <= '0;
            blink_phase_reg  <= 1'b0;
        end else begin
            shadow_reg       <= shadow_next;
            cursor_reg       <= cursor_next;
            blink_cnt_reg    <= blink_cnt_next;
            blink_phase_reg  <= blink_phase_next;
            commit_valid_reg <= do_commit;
            if (do_commit) begin
                inp_reg  <= shadow_reg[DATA_WIDTH-1:0];
                par_reg  <= shadow_reg[2*DATA_WIDTH-1:DATA_WIDTH];
                prop_reg <= shadow_reg[SHADOW_W-1:2*DATA_WIDTH];
            end
        end
    end

    // Display: 16-bit window holding the cursor, zero-filled past the buffer top
    logic [PAD_W-1:0] shadow_pad;
    logic [15:0]      windows [NWIN];

    assign shadow_pad = PAD_W'(shadow_reg);

    generate
        for (gi = 0; gi < NWIN; gi++) begin : g_win
            assign windows[gi] = shadow_pad[16*gi +: 16];
        end
        if (CW > 2) begin : g_multi_win
            assign display_number = windows[cursor_reg[CW-1:2]];
        end else begin : g_single_win
            assign display_number = windows[0];
        end
        for (gi = 0; gi < 4; gi++) begin : g_blank
            assign digit_blank[gi] = blink_phase_reg && (cursor_reg[1:0] == 2'(gi));
        end
    endgenerate

    assign inp          = inp_reg;
    assign par          = par_reg;
    assign prop         = prop_reg;
    assign commit_valid = commit_valid_reg;
    assign cursor       = cursor_reg;

endmodule

// File: tb/tb_hex_data_entry.sv
// Scoreboard bench for hex_data_entry: a behavioural model predicts every
// register; committed values are queued and checked when commit_valid fires.
module tb_hex_data_entry;

    localparam int DW = 8;
    localparam int BC = 4;
    localparam int CW = $clog2(DW);

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            key_inc = 1'b0, key_dec = 1'b0, key_next = 1'b0;
    logic            key_commit = 1'b0, preset_load = 1'b0;
    logic [DW-1:0]   preset_inp = '0, preset_par = '0;
    logic [2*DW-1:0] preset_prop = '0;
    logic [DW-1:0]   inp, par;
    logic [2*DW-1:0] prop;
    logic            commit_valid;
    logic [CW-1:0]   cursor;
    logic [15:0]     display_number;
    logic [3:0]      digit_blank;

    hex_data_entry #(.DATA_WIDTH(DW), .BLINK_CYCLES(BC)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .key_inc        (key_inc),
        .key_dec        (key_dec),
        .key_next       (key_next),
        .key_commit     (key_commit),
        .preset_load    (preset_load),
        .preset_inp     (preset_inp),
        .preset_par     (preset_par),
        .preset_prop    (preset_prop),
        .inp            (inp),
        .par            (par),
        .prop           (prop),
        .commit_valid   (commit_valid),
        .cursor         (cursor),
        .display_number (display_number),
        .digit_blank    (digit_blank)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0]   i;
        logic [DW-1:0]   p;
        logic [2*DW-1:0] pr;
    } commit_t;

    commit_t exp_q[$];
    int      tests_run = 0;
    int      tests_failed = 0;
    int      step_no = 0;

    logic [4*DW-1:0] m_shadow = '0;
    logic [DW-1:0]   m_inp = '0, m_par = '0;
    logic [2*DW-1:0] m_prop = '0;
    int              m_cursor = 0;
    int              m_cnt = 0;
    logic            m_phase = 1'b0;
    logic            m_cv = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", tag, step_no, got, exp);
        end
    endtask

    task automatic compare_all();
        logic [63:0] exp_disp;
        logic [3:0]  exp_blank;
        exp_disp  = (64'(m_shadow) >> (16 * (m_cursor / 4))) & 64'hFFFF;
        exp_blank = m_phase ? (4'b0001 << (m_cursor % 4)) : 4'b0000;
        check("cursor",       64'(cursor),         64'(m_cursor));
        check("display",      64'(display_number), exp_disp);
        check("digit_blank",  64'(digit_blank),    64'(exp_blank));
        check("inp",          64'(inp),            64'(m_inp));
        check("par",          64'(par),            64'(m_par));
        check("prop",         64'(prop),           64'(m_prop));
        check("commit_valid", 64'(commit_valid),   64'(m_cv));
    endtask

    // One clock edge of stimulus; the model is advanced alongside
    task automatic step(input logic rst_n, input logic inc, input logic dec, input logic nxt,
                        input logic com, input logic pre, input logic [4*DW-1:0] pv);
        logic [3:0] nib;
        reset_n     = rst_n;
        key_inc     = inc;
        key_dec     = dec;
        key_next    = nxt;
        key_commit  = com;
        preset_load = pre;
        {preset_prop, preset_par, preset_inp} = pv;
        m_cv = 1'b0;
        if (!rst_n) begin
            m_shadow = '0; m_inp = '0; m_par = '0; m_prop = '0;
            m_cursor = 0; m_cnt = 0; m_phase = 1'b0;
        end else begin
            if (pre) begin
                m_shadow = pv;
            end else if (com) begin
                m_inp  = m_shadow[DW-1:0];
                m_par  = m_shadow[2*DW-1:DW];
                m_prop = m_shadow[4*DW-1:2*DW];
                m_cv   = 1'b1;
                exp_q.push_back('{m_inp, m_par, m_prop});
            end else begin
                nib = m_shadow[4*m_cursor +: 4];
                if (inc && !dec) nib = nib + 4'd1;
                else if (dec && !inc) nib = nib - 4'd1;
                m_shadow[4*m_cursor +: 4] = nib;
                if (nxt) m_cursor = (m_cursor + 1) % DW;
            end
            if (inc || dec || nxt || com || pre) begin
                m_cnt = 0; m_phase = 1'b0;
            end else if (m_cnt == BC - 1) begin
                m_cnt = 0; m_phase = ~m_phase;
            end else begin
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        key_inc = 0; key_dec = 0; key_next = 0; key_commit = 0; preset_load = 0;
        reset_n = 1'b1;
        step_no++;
        $display("[TB] step %0d rst_n=%0b inc=%0b dec=%0b next=%0b commit=%0b preset=%0b -> cursor=%0d disp=%h blank=%b inp=%h par=%h prop=%h cv=%0b",
                 step_no, rst_n, inc, dec, nxt, com, pre, cursor, display_number, digit_blank,
                 inp, par, prop, commit_valid);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 0, '0);
    endtask

    // commit_valid pulses are matched one-for-one against queued commits
    always @(negedge clk) begin
        commit_t c;
        if (commit_valid) begin
            if (exp_q.size() == 0) begin
                check("commit_spurious", 64'(1), 64'(0));
            end else begin
                c = exp_q.pop_front();
                check("commit_inp",  64'(inp),  64'(c.i));
                check("commit_par",  64'(par),  64'(c.p));
                check("commit_prop", 64'(prop), 64'(c.pr));
            end
        end
    end

    initial begin
        // reset with garbage on the keys
        step(0, 1, 0, 1, 1, 1, 32'hDEADBEEF);
        step(0, 0, 0, 0, 0, 0, '0);

        // three increments, then commit
        for (int k = 0; k < 3; k++) step(1, 1, 0, 0, 0, 0, '0);
        check("disp_after_3inc", 64'(display_number), 64'h0003);
        step(1, 0, 0, 0, 1, 0, '0);
        idle(2);

        // nibble wrap both ways and inc+dec cancel
        for (int k = 0; k < 13; k++) step(1, 1, 0, 0, 0, 0, '0);
        for (int k = 0; k < 16; k++) step(1, 1, 0, 0, 0, 0, '0);
        step(1, 0, 1, 0, 0, 0, '0);
        check("dec_wrap", 64'(display_number), 64'h000F);
        step(1, 1, 1, 0, 0, 0, '0);

        // cursor walk and wrap, next coinciding with inc
        for (int k = 0; k < 7; k++) step(1, 0, 0, 1, 0, 0, '0);
        check("cursor_7", 64'(cursor), 64'(7));
        step(1, 0, 0, 1, 0, 0, '0);
        for (int k = 0; k < 3; k++) step(1, 0, 0, 1, 0, 0, '0);
        step(1, 1, 0, 1, 0, 0, '0);
        check("cursor_after_next_inc", 64'(cursor), 64'(4));

        // preset beats a simultaneous commit, then a plain commit publishes it
        step(1, 0, 0, 0, 1, 1, {16'h5678, 8'h34, 8'h12});
        step(1, 0, 0, 0, 1, 0, '0);
        idle(1);

        // blink on cursor 1, then restart by key_next
        for (int k = 0; k < 5; k++) step(1, 0, 0, 1, 0, 0, '0);
        idle(10);
        step(1, 0, 0, 1, 0, 0, '0);
        idle(6);

        // uncommitted edit discarded by reset
        for (int k = 0; k < 3; k++) step(1, 0, 0, 1, 0, 0, '0);
        for (int k = 0; k < 10; k++) step(1, 1, 0, 0, 0, 0, '0);
        step(0, 0, 0, 0, 0, 0, '0);
        idle(3);

        // random traffic
        for (int k = 0; k < 120; k++) begin
            step(($urandom_range(0, 29) != 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0),
                 ($urandom_range(0, 12) == 0), 32'($urandom));
        end
        idle(2);

        check("commit_missing", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
